// File: rtl/path_walker.sv
// Walks a parent-linked node chain from goal_index back to the root, emitting one waypoint per node.
// Latency: first wp_valid three cycles after walk_pulse; three cycles per waypoint with wp_ready held high.
// Backpressure: wp_valid/wp_x/wp_y/wp_last hold until wp_ready; optional cost check via PATH_WALKER_COST_CHECK_EN.
module path_walker #(
    parameter int DEPTH = 1500,
    parameter int IDX_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             walk_pulse,
    input  logic [IDX_W-1:0] goal_index,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_addr,
    input  logic [9:0]       rd_x,
    input  logic [9:0]       rd_y,
    input  logic [31:0]      rd_parent,
    input  logic [31:0]      rd_cost,
    output logic [9:0]       wp_x,
    output logic [9:0]       wp_y,
    output logic             wp_valid,
    input  logic             wp_ready,
    output logic             wp_last,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] wp_count
);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE, ERR} state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [IDX_W-1:0] ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] parent_idx;
    logic [9:0]       x_q, y_q;
    logic             last_q;
    logic [IDX_W-1:0] cnt_q;
    logic             err_q;

    logic parent_root, parent_ok, cost_ok, goal_ok, xfer, guard_hit;

`ifdef PATH_WALKER_COST_CHECK_EN
    logic [31:0] cost_q, prev_cost;
    logic        have_prev;
    // Costs must strictly fall from one emitted node to the next.
    assign cost_ok = !have_prev || (rd_cost < prev_cost);
`else
    logic unused_cost;
    assign unused_cost = ^rd_cost;
    assign cost_ok     = 1'b1;
`endif

    assign parent_root = (rd_parent == 32'hFFFF_FFFF);
    // Negative parents other than -1 compare as huge unsigned values and fall out of range.
    assign parent_ok   = parent_root || (rd_parent < DEPTH_W);
    assign goal_ok     = (32'(goal_index) < DEPTH_W);
    assign xfer        = (state == EMIT) && wp_ready;
    assign guard_hit   = ((32'(cnt_q) + 32'd1) == DEPTH_W);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (walk_pulse) state_nxt = goal_ok ? FETCH : ERR;
            FETCH:   state_nxt = WAIT;
            WAIT:    state_nxt = (parent_ok && cost_ok) ? EMIT : ERR;
            EMIT: begin
                if (wp_ready) begin
                    if (last_q)         state_nxt = DONE;
                    else if (guard_hit) state_nxt = ERR;
                    else                state_nxt = FETCH;
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cur_idx    <= '0;
            parent_idx <= '0;
            x_q        <= '0;
            y_q        <= '0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
`ifdef PATH_WALKER_COST_CHECK_EN
            cost_q     <= '0;
            prev_cost  <= '0;
            have_prev  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && walk_pulse) begin
                cur_idx <= goal_index;
                cnt_q   <= '0;
                err_q   <= 1'b0;
`ifdef PATH_WALKER_COST_CHECK_EN
                have_prev <= 1'b0;
`endif
            end
            if (state == WAIT) begin
                x_q        <= rd_x;
                y_q        <= rd_y;
                last_q     <= parent_root;
                parent_idx <= rd_parent[IDX_W-1:0];
`ifdef PATH_WALKER_COST_CHECK_EN
                cost_q     <= rd_cost;
`endif
            end
            if (xfer) begin
                cnt_q   <= cnt_q + ONE;
                cur_idx <= parent_idx;
`ifdef PATH_WALKER_COST_CHECK_EN
                prev_cost <= cost_q;
                have_prev <= 1'b1;
`endif
            end
            // Placed after the walk_pulse clear so an out-of-range goal still flags.
            if (state_nxt == ERR) err_q <= 1'b1;
        end
    end

    assign rd_en    = (state == FETCH);
    assign rd_addr  = rd_en ? cur_idx : '0;
    assign wp_valid = (state == EMIT);
    assign wp_last  = wp_valid && last_q;
    assign wp_x     = x_q;
    assign wp_y     = y_q;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign error    = err_q;
    assign wp_count = cnt_q;

endmodule

// File: tb/tb_path_walker.sv
module tb_path_walker;
    localparam int DEPTH = 1500;
    localparam int IDX_W = 11;

    logic             clk = 1'b0;
    logic             reset, walk_pulse, wp_ready;
    logic [IDX_W-1:0] goal_index, rd_addr, wp_count;
    logic             rd_en, wp_valid, wp_last, busy, done, error;
    logic [9:0]       rd_x, rd_y, wp_x, wp_y;
    logic [31:0]      rd_parent, rd_cost;

    path_walker #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .walk_pulse(walk_pulse), .goal_index(goal_index),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_x(rd_x), .rd_y(rd_y),
        .rd_parent(rd_parent), .rd_cost(rd_cost), .wp_x(wp_x), .wp_y(wp_y),
        .wp_valid(wp_valid), .wp_ready(wp_ready), .wp_last(wp_last),
        .busy(busy), .done(done), .error(error), .wp_count(wp_count)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int mem_x[2048], mem_y[2048], mem_parent[2048], mem_cost[2048];

    // One-cycle read latency node memory.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_x      <= 10'(mem_x[rd_addr]);
            rd_y      <= 10'(mem_y[rd_addr]);
            rd_parent <= mem_parent[rd_addr];
            rd_cost   <= mem_cost[rd_addr];
        end
    end

    int cyc = 0, pulse_cyc = 0, first_vld = -1, done_n = 0, last_n = 0, stab_err = 0;
    int obs_x[$], obs_y[$], obs_last[$], fetch_q[$];
    logic hold_p = 1'b0, hl;
    logic [9:0] hx, hy;

    always @(negedge clk) begin
        cyc++;
        if (reset !== 1'b1) begin
            hold_p = 1'b0;
        end else begin
            if (hold_p && !(wp_valid === 1'b1 && wp_x === hx && wp_y === hy && wp_last === hl))
                stab_err++;
            if (walk_pulse && !busy) begin pulse_cyc = cyc; first_vld = -1; end
            if (wp_valid && first_vld < 0) first_vld = cyc;
            if (rd_en) fetch_q.push_back(int'(rd_addr));
            if (done) done_n++;
            if (wp_valid && wp_ready) begin
                obs_x.push_back(int'(wp_x));
                obs_y.push_back(int'(wp_y));
                obs_last.push_back(int'(wp_last));
                if (wp_last) last_n++;
            end
            hold_p = wp_valid && !wp_ready;
            hx = wp_x; hy = wp_y; hl = wp_last;
        end
    end

    int rmode = 0, stall_n = 0;
    initial begin
        wp_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                1: wp_ready = ($urandom_range(0, 2) != 0);
                2: if (wp_valid && wp_count == 1 && stall_n < 4) begin
                       wp_ready = 1'b0; stall_n++;
                   end else wp_ready = 1'b1;
                3: wp_ready = (wp_count == 0);
                default: wp_ready = 1'b1;
            endcase
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ":rd_en"}, rd_en, 0);       chk({tag, ":rd_addr"}, rd_addr, 0);
        chk({tag, ":wp_valid"}, wp_valid, 0); chk({tag, ":wp_last"}, wp_last, 0);
        chk({tag, ":wp_x"}, wp_x, 0);         chk({tag, ":wp_y"}, wp_y, 0);
        chk({tag, ":busy"}, busy, 0);         chk({tag, ":done"}, done, 0);
        chk({tag, ":error"}, error, 0);       chk({tag, ":wp_count"}, wp_count, 0);
    endtask

    // Reference: follow parent links from the goal and apply the walk rules directly.
    int exp_idx[$], exp_fetch[$];
    bit exp_err;
    function automatic void model(input int goal);
        int cur, p, prev_c;
        bit have_prev;
        exp_idx.delete(); exp_fetch.delete(); exp_err = 0;
        have_prev = 0; prev_c = 0;
        if (goal >= DEPTH) begin exp_err = 1; return; end
        cur = goal;
        for (int k = 0; k <= DEPTH; k++) begin
            exp_fetch.push_back(cur);
            p = mem_parent[cur];
`ifdef PATH_WALKER_COST_CHECK_EN
            if (have_prev && $unsigned(mem_cost[cur]) >= $unsigned(prev_c)) begin exp_err = 1; return; end
`endif
            if (p != -1 && (p < 0 || p >= DEPTH)) begin exp_err = 1; return; end
            exp_idx.push_back(cur);
            if (p == -1) return;
            if (exp_idx.size() == DEPTH) begin exp_err = 1; return; end
            prev_c = mem_cost[cur]; have_prev = 1;
            cur = p;
        end
    endfunction

    task automatic run_walk(input int goal, input int mode, input bit poke, input string tag);
        int n, m;
        model(goal);
        rmode = mode; stall_n = 0;
        obs_x.delete(); obs_y.delete(); obs_last.delete(); fetch_q.delete();
        done_n = 0; last_n = 0; stab_err = 0;
        goal_index = IDX_W'(goal);
        walk_pulse = 1'b1;
        step();
        walk_pulse = 1'b0;
        chk({tag, ":err_at_start"}, error, goal >= DEPTH);
        chk({tag, ":cnt_at_start"}, wp_count, 0);
        if (poke) begin
            goal_index = IDX_W'($urandom_range(0, DEPTH - 1));
            walk_pulse = 1'b1;
            step();
            walk_pulse = 1'b0;
        end
        n = 0;
        while (busy && n < 20000) begin step(); n++; end
        chk({tag, ":finished"}, busy, 0);
        chk({tag, ":error"}, error, exp_err);
        chk({tag, ":wp_count"}, wp_count, exp_idx.size());
        chk({tag, ":done_pulses"}, done_n, exp_err ? 0 : 1);
        chk({tag, ":n_wp"}, obs_x.size(), exp_idx.size());
        m = (obs_x.size() < exp_idx.size()) ? obs_x.size() : exp_idx.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s:wp%0d_x", tag, i), obs_x[i], mem_x[exp_idx[i]]);
            chk($sformatf("%s:wp%0d_y", tag, i), obs_y[i], mem_y[exp_idx[i]]);
            chk($sformatf("%s:wp%0d_last", tag, i), obs_last[i],
                (i == exp_idx.size() - 1 && !exp_err) ? 1 : 0);
        end
        chk({tag, ":n_fetch"}, fetch_q.size(), exp_fetch.size());
        m = (fetch_q.size() < exp_fetch.size()) ? fetch_q.size() : exp_fetch.size();
        for (int i = 0; i < m; i++)
            chk($sformatf("%s:fetch%0d", tag, i), fetch_q[i], exp_fetch[i]);
        chk({tag, ":stable"}, stab_err, 0);
        rmode = 0;
        step();
    endtask

    initial begin
        int c[8];
        int len, goal, n, sz;
        bit dup;
        reset = 1'b0; walk_pulse = 1'b0; goal_index = '0;
        for (int i = 0; i < 2048; i++) begin
            mem_x[i] = $urandom_range(0, 1023);
            mem_y[i] = $urandom_range(0, 1023);
            mem_parent[i] = -1;
            mem_cost[i] = 0;
        end
        step(3);
        chk_zero("reset");
        reset = 1'b1;
        step();

        mem_parent[5] = 3; mem_parent[3] = 0; mem_parent[0] = -1;
        mem_cost[5] = 30;  mem_cost[3] = 20;  mem_cost[0] = 10;
        run_walk(5, 0, 0, "chain");
        chk("chain:first_vld_latency", first_vld - pulse_cyc, 3);
        run_walk(5, 2, 0, "stall");
        chk("stall:stall_cycles", stall_n, 4);

        mem_parent[7] = 2000;
        run_walk(7, 0, 0, "bad_parent");
        run_walk(5, 0, 0, "after_err");
        run_walk(1600, 0, 0, "goal_oob");
        mem_parent[9] = -5;
        run_walk(9, 1, 0, "neg_parent");

        mem_parent[4] = 6; mem_parent[6] = 4; mem_cost[4] = 5; mem_cost[6] = 3;
        run_walk(4, 0, 0, "loop");
        chk("loop:no_last", last_n, 0);

        mem_parent[12] = 13; mem_parent[13] = -1; mem_cost[12] = 10; mem_cost[13] = 12;
        run_walk(12, 0, 0, "cost_rise");

        // Reset while the second waypoint is being held off.
        obs_x.delete(); obs_y.delete(); obs_last.delete();
        rmode = 3;
        goal_index = 11'd5; walk_pulse = 1'b1; step(); walk_pulse = 1'b0;
        n = 0;
        while (!(wp_valid && wp_count == 1) && n < 100) begin step(); n++; end
        chk("rst:reached_wp2", wp_valid && wp_count == 1, 1);
        step(2);
        reset = 1'b0;
        step();
        chk_zero("rst_mid");
        reset = 1'b1;
        sz = obs_x.size();
        step(10);
        chk("rst:no_more_wp", obs_x.size(), sz);
        chk("rst:idle", busy, 0);
        rmode = 0;
        run_walk(5, 0, 0, "post_rst");

        for (int t = 0; t < 25; t++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                do begin
                    c[i] = $urandom_range(20, DEPTH - 1);
                    dup = 0;
                    for (int j = 0; j < i; j++) if (c[j] == c[i]) dup = 1;
                end while (dup);
                mem_x[c[i]] = $urandom_range(0, 1023);
                mem_y[c[i]] = $urandom_range(0, 1023);
                mem_cost[c[i]] = 1000 - 10 * i + (($urandom_range(0, 5) == 0) ? 50 : 0);
            end
            for (int i = 0; i < len - 1; i++) mem_parent[c[i]] = c[i + 1];
            case ($urandom_range(0, 9))
                0:       mem_parent[c[len - 1]] = $urandom_range(DEPTH, 100000);
                1:       mem_parent[c[len - 1]] = -2;
                default: mem_parent[c[len - 1]] = -1;
            endcase
            goal = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, 2047) : c[0];
            run_walk(goal, 1, (goal < DEPTH) && ($urandom_range(0, 1) == 1), $sformatf("rnd%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
